// File: rtl/branch_pkg.sv
// Shared decode constants, condition codes, NZCV bit positions and FSM state
// for the decode-side branch resolver (branch_unit and branch_cond_eval).
// No logic; constants and types only.
package branch_pkg;

  // Opcode fields, compared against the instruction's top bits.
  localparam logic [5:0]  OP_B     = 6'b000101;      // instr[31:26]
  localparam logic [5:0]  OP_BL    = 6'b100101;      // instr[31:26]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;    // instr[31:24]
  localparam logic [7:0]  OP_BCOND = 8'b01010100;    // instr[31:24]
  localparam logic [10:0] OP_BR    = 11'b11010110000; // instr[31:21]

  // B.cond condition codes (instr[4:0]).
  localparam logic [4:0] COND_EQ = 5'h00;
  localparam logic [4:0] COND_NE = 5'h01;
  localparam logic [4:0] COND_GE = 5'h0A;
  localparam logic [4:0] COND_LT = 5'h0B;
  localparam logic [4:0] COND_GT = 5'h0C;
  localparam logic [4:0] COND_LE = 5'h0D;

  // Bit positions inside the {N,Z,C,V} vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Decode <-> branch resolver bundle: fetched instruction, forwarded operands
// and flags in; PC redirect, link request, flags and slot status out.
// slave = branch_unit, master = decode stage driving it. Optional perf
// counters appear only with BRANCH_PERF_EN defined.
interface branch_unit_if;
  logic [31:0] instr;
  logic        instrValid;
  logic [63:0] rtVal;
  logic [63:0] rnVal;
  logic [3:0]  aluFlags;
  logic        setFlags;
  logic [63:0] destAddr;
  logic        branchCond;
  logic        setPCReg;
  logic [63:0] setPC;
  logic        linkWrite;
  logic [3:0]  flags;
  logic        inSlot;
`ifdef BRANCH_PERF_EN
  logic [31:0] branchCount;
  logic [31:0] takenCount;
`endif

  modport slave (
    input  instr, instrValid, rtVal, rnVal, aluFlags, setFlags,
    output destAddr, branchCond, setPCReg, setPC, linkWrite, flags, inSlot
`ifdef BRANCH_PERF_EN
    , output branchCount, takenCount
`endif
  );

  modport master (
    output instr, instrValid, rtVal, rnVal, aluFlags, setFlags,
    input  destAddr, branchCond, setPCReg, setPC, linkWrite, flags, inSlot
`ifdef BRANCH_PERF_EN
    , input branchCount, takenCount
`endif
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Evaluates a B.cond condition code against an NZCV vector.
// Purely combinational, zero latency; no handshake.
// Ports: cond[4:0] in, nzcv[3:0] in ({N,Z,C,V}), taken out.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [4:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic n_flag, z_flag, v_flag, ge;
  // C is carried in the vector but no supported condition reads it.
  logic unused_c;

  assign n_flag   = nzcv[FLAG_N];
  assign z_flag   = nzcv[FLAG_Z];
  assign v_flag   = nzcv[FLAG_V];
  assign unused_c = nzcv[FLAG_C];
  assign ge       = (n_flag == v_flag);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z_flag;
      COND_NE: taken = ~z_flag;
      COND_GE: taken = ge;
      COND_LT: taken = ~ge;
      COND_GT: taken = ~z_flag & ge;
      COND_LE: taken = ~(~z_flag & ge);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Decode-side branch resolver: decodes B/BL/CBZ/B.cond/BR, holds NZCV, drives
// the PC redirect and X30 link request, and enforces one branch delay slot.
// Redirect outputs are combinational (zero latency); state/flags update on the
// rising edge. No backpressure: instrValid=0 is a stall and holds the slot.
// Ports: clk, reset (async, active-high), bus (branch_unit_if.slave).
// Optional: BRANCH_PERF_EN adds saturating branchCount/takenCount.
module branch_unit
  import branch_pkg::*;
(
  input logic            clk,
  input logic            reset,
  branch_unit_if.slave   bus
);

  br_state_e   state_q, state_d;
  logic [3:0]  flags_q, flags_d;

  logic is_b, is_bl, is_cbz, is_bcond, is_br, is_branch;
  logic cond_taken, live, taken;
  logic [3:0]  cond_flags;
  logic [63:0] dest_addr;

  assign is_b      = (bus.instr[31:26] == OP_B);
  assign is_bl     = (bus.instr[31:26] == OP_BL);
  assign is_cbz    = (bus.instr[31:24] == OP_CBZ);
  assign is_bcond  = (bus.instr[31:24] == OP_BCOND);
  assign is_br     = (bus.instr[31:21] == OP_BR);
  assign is_branch = is_b | is_bl | is_cbz | is_bcond | is_br;

  // Bypass: a flag write in this cycle is visible to the B.cond in decode now.
  assign cond_flags = bus.setFlags ? bus.aluFlags : flags_q;

  branch_cond_eval u_cond (
    .cond  (bus.instr[4:0]),
    .nzcv  (cond_flags),
    .taken (cond_taken)
  );

  // A branch may act only when valid, outside the delay slot and out of reset.
  assign live  = bus.instrValid & (state_q == IDLE) & ~reset;
  assign taken = live & (is_b | is_bl | is_br
                         | (is_cbz & (bus.rtVal == 64'd0))
                         | (is_bcond & cond_taken));

  always_comb begin
    dest_addr = 64'd0;
    if (is_b || is_bl)
      dest_addr = {{36{bus.instr[25]}}, bus.instr[25:0], 2'b00};
    else if (is_cbz || is_bcond)
      dest_addr = {{43{bus.instr[23]}}, bus.instr[23:5], 2'b00};
  end

  assign bus.destAddr   = reset ? 64'd0 : dest_addr;
  assign bus.branchCond = taken & ~is_br;
  assign bus.setPCReg   = taken & is_br;
  assign bus.setPC      = (taken & is_br) ? bus.rnVal : 64'd0;
  assign bus.linkWrite  = taken & is_bl;
  assign bus.flags      = reset ? 4'd0 : flags_q;
  assign bus.inSlot     = ~reset & (state_q == SLOT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (taken) state_d = SLOT;
      SLOT:    if (bus.instrValid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flags_d = bus.setFlags ? bus.aluFlags : flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  always_comb begin
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (live && is_branch && (branch_count_q != 32'hFFFF_FFFF))
      branch_count_d = branch_count_q + 32'd1;
    if (taken && (taken_count_q != 32'hFFFF_FFFF))
      taken_count_d = taken_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_q <= 32'd0;
      taken_count_q  <= 32'd0;
    end else begin
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign bus.branchCount = reset ? 32'd0 : branch_count_q;
  assign bus.takenCount  = reset ? 32'd0 : taken_count_q;
`else
  // Branch classification only feeds the perf counters.
  logic unused_is_branch;
  assign unused_is_branch = is_branch;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a vector table (each entry applied from IDLE
// with its flags preloaded) plus hand sequences for slot suppression and reset.
module tb_branch_unit;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_unit_if bif ();

  branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [63:0] rt;
    logic [63:0] rn;
    logic [3:0]  pre_flags;
    logic        set_flags;
    logic [3:0]  alu_flags;
    logic [63:0] exp_dest;
    logic        exp_bc;
    logic        exp_spr;
    logic [63:0] exp_spc;
    logic        exp_lw;
    logic        exp_slot;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic [63:0] rt,
                       input logic [63:0] rn, input logic [3:0] alu, input logic sf);
    bif.instr      = i;
    bif.instrValid = v;
    bif.rtVal      = rt;
    bif.rnVal      = rn;
    bif.aluFlags   = alu;
    bif.setFlags   = sf;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    // Preload the flag register and make sure we start in IDLE.
    @(negedge clk); drive(NOP, 1'b1, 64'd0, 64'd0, v.pre_flags, 1'b1);
    @(negedge clk); drive(v.instr, v.valid, v.rt, v.rn, v.alu_flags, v.set_flags);
    #1;
    chk($sformatf("v%0d.destAddr", idx),   bif.destAddr,   v.exp_dest);
    chk($sformatf("v%0d.branchCond", idx), bif.branchCond, v.exp_bc);
    chk($sformatf("v%0d.setPCReg", idx),   bif.setPCReg,   v.exp_spr);
    chk($sformatf("v%0d.setPC", idx),      bif.setPC,      v.exp_spc);
    chk($sformatf("v%0d.linkWrite", idx),  bif.linkWrite,  v.exp_lw);
    @(posedge clk); #1;
    chk($sformatf("v%0d.inSlot", idx), bif.inSlot, v.exp_slot);
    chk($sformatf("v%0d.flags", idx),  bif.flags,  v.exp_flags);
    // Valid NOP consumes any delay slot.
    @(negedge clk); drive(NOP, 1'b1, 64'd0, 64'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    chk($sformatf("v%0d.slot_exit", idx), bif.inSlot, 1'b0);
  endtask

  initial begin
    //           instr         vld rt     rn      pre    sf  alu    dest                    bc spr spc     lw slot flags
    vecs[0]  = '{32'h14000003, 1, 64'd0, 64'd0,   4'h0, 0, 4'h0, 64'd12,                 1, 0, 64'd0,   0, 1, 4'h0}; // B +3
    vecs[1]  = '{32'h17FFFFF9, 1, 64'd0, 64'd0,   4'h0, 0, 4'h0, 64'hFFFFFFFFFFFFFFE4,   1, 0, 64'd0,   0, 1, 4'h0}; // B -7
    vecs[2]  = '{32'h94000002, 1, 64'd0, 64'd0,   4'h0, 0, 4'h0, 64'd8,                  1, 0, 64'd0,   1, 1, 4'h0}; // BL +2
    vecs[3]  = '{32'hB4000041, 1, 64'd0, 64'd0,   4'h0, 0, 4'h0, 64'd8,                  1, 0, 64'd0,   0, 1, 4'h0}; // CBZ rt=0
    vecs[4]  = '{32'hB4000041, 1, 64'd5, 64'd0,   4'h0, 0, 4'h0, 64'd8,                  0, 0, 64'd0,   0, 0, 4'h0}; // CBZ rt=5
    vecs[5]  = '{32'h5400008B, 1, 64'd0, 64'd0,   4'h8, 0, 4'h0, 64'd16,                 1, 0, 64'd0,   0, 1, 4'h8}; // LT reg
    vecs[6]  = '{32'h5400008B, 1, 64'd0, 64'd0,   4'h9, 1, 4'h8, 64'd16,                 1, 0, 64'd0,   0, 1, 4'h8}; // LT bypass
    vecs[7]  = '{32'h5400008B, 1, 64'd0, 64'd0,   4'h9, 0, 4'h0, 64'd16,                 0, 0, 64'd0,   0, 0, 4'h9}; // LT false
    vecs[8]  = '{32'h54000080, 1, 64'd0, 64'd0,   4'h4, 0, 4'h0, 64'd16,                 1, 0, 64'd0,   0, 1, 4'h4}; // EQ Z=1
    vecs[9]  = '{32'h54000081, 1, 64'd0, 64'd0,   4'h4, 0, 4'h0, 64'd16,                 0, 0, 64'd0,   0, 0, 4'h4}; // NE Z=1
    vecs[10] = '{32'h5400008C, 1, 64'd0, 64'd0,   4'h0, 0, 4'h0, 64'd16,                 1, 0, 64'd0,   0, 1, 4'h0}; // GT
    vecs[11] = '{32'h5400008C, 1, 64'd0, 64'd0,   4'h4, 0, 4'h0, 64'd16,                 0, 0, 64'd0,   0, 0, 4'h4}; // GT Z=1
    vecs[12] = '{32'h5400008D, 1, 64'd0, 64'd0,   4'h4, 0, 4'h0, 64'd16,                 1, 0, 64'd0,   0, 1, 4'h4}; // LE Z=1
    vecs[13] = '{32'h5400008A, 1, 64'd0, 64'd0,   4'h9, 0, 4'h0, 64'd16,                 1, 0, 64'd0,   0, 1, 4'h9}; // GE N=V=1
    vecs[14] = '{32'h5400008E, 1, 64'd0, 64'd0,   4'h4, 0, 4'h0, 64'd16,                 0, 0, 64'd0,   0, 0, 4'h4}; // cond 0xE
    vecs[15] = '{32'hD61F03C0, 1, 64'd0, 64'h400, 4'h0, 0, 4'h0, 64'd0,                  0, 1, 64'h400, 0, 1, 4'h0}; // BR X30
    vecs[16] = '{32'h14000003, 0, 64'd0, 64'd0,   4'h0, 0, 4'h0, 64'd12,                 0, 0, 64'd0,   0, 0, 4'h0}; // B invalid

    // Reset state: a valid B with a flag write must not leak through.
    drive(32'h14000003, 1'b1, 64'd0, 64'd0, 4'hF, 1'b1);
    #22;
    chk("rst.destAddr",   bif.destAddr,   64'd0);
    chk("rst.branchCond", bif.branchCond, 1'b0);
    chk("rst.inSlot",     bif.inSlot,     1'b0);
    chk("rst.flags",      bif.flags,      4'h0);
    @(negedge clk); drive(NOP, 1'b1, 64'd0, 64'd0, 4'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // BR, stall in slot, then a suppressed B.
    @(negedge clk); drive(32'hD61F03C0, 1'b1, 64'd0, 64'h400, 4'h0, 1'b0);
    #1;
    chk("seq_br.setPCReg", bif.setPCReg, 1'b1);
    chk("seq_br.setPC",    bif.setPC,    64'h400);
    @(posedge clk); #1;
    chk("seq_br.inSlot", bif.inSlot, 1'b1);
    @(negedge clk); drive(32'h94000002, 1'b0, 64'd0, 64'd0, 4'h0, 1'b0);
    #1;
    chk("seq_stall.branchCond", bif.branchCond, 1'b0);
    @(posedge clk); #1;
    chk("seq_stall.inSlot", bif.inSlot, 1'b1);
    @(negedge clk); drive(32'h94000002, 1'b1, 64'd0, 64'd0, 4'h0, 1'b0);
    #1;
    chk("seq_slot_bl.branchCond", bif.branchCond, 1'b0);
    chk("seq_slot_bl.linkWrite",  bif.linkWrite,  1'b0);
    chk("seq_slot_bl.destAddr",   bif.destAddr,   64'd8);
    @(posedge clk); #1;
    chk("seq_slot_bl.inSlot", bif.inSlot, 1'b0);
    @(negedge clk); drive(32'h14000003, 1'b1, 64'd0, 64'd0, 4'h0, 1'b0);
    #1;
    chk("seq_slot_b.branchCond", bif.branchCond, 1'b1);
    @(posedge clk); #1;
    chk("seq_slot_b.inSlot", bif.inSlot, 1'b1);

    // Reset mid-slot with non-zero flags.
    @(negedge clk); drive(NOP, 1'b1, 64'd0, 64'd0, 4'hF, 1'b1);
    @(posedge clk); #1;
    chk("seq_rst.pre_flags", bif.flags, 4'hF);
    @(negedge clk); drive(32'h14000003, 1'b1, 64'd0, 64'd0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("seq_rst.pre_slot", bif.inSlot, 1'b1);
    @(negedge clk); drive(32'h14000003, 1'b0, 64'd0, 64'd0, 4'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("seq_rst.inSlot",     bif.inSlot,     1'b0);
    chk("seq_rst.flags",      bif.flags,      4'h0);
    chk("seq_rst.branchCond", bif.branchCond, 1'b0);
    @(negedge clk);
    drive(32'h14000003, 1'b1, 64'd0, 64'd0, 4'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk("seq_post.branchCond", bif.branchCond, 1'b1);
    chk("seq_post.destAddr",   bif.destAddr,   64'd12);
    @(posedge clk); #1;
    chk("seq_post.inSlot", bif.inSlot, 1'b1);
    chk("seq_post.flags",  bif.flags,  4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Decode-side branch resolver that drives the program counter's `destAddr`, `branchCond`, `setPCReg` and `setPC` inputs. It inspects the fetched LEGv8 instruction, holds the architectural NZCV flags, evaluates B, BL, CBZ, B.cond and BR, and enforces a single branch delay slot. It sits between instruction fetch and the PC in the pipelined datapath, and also drives the X30 link-write request for BL.

## Interface
Parameters:
- None. All widths are fixed: 64-bit addresses and 32-bit instructions.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction currently in decode.
- `instrValid` in 1: `instr` is live this cycle. Low means a stall or bubble.
- `rtVal` in 64: forwarded value of Rt (`instr[4:0]`), used for the CBZ zero test.
- `rnVal` in 64: forwarded value of Rn (`instr[9:5]`), used as the BR target.
- `aluFlags` in 4: {N,Z,C,V} produced by execute this cycle.
- `setFlags` in 1: execute is writing `aluFlags` this cycle.
- `destAddr` out 64: sign-extended branch offset shifted left by 2.
- `branchCond` out 1: PC takes PC + `destAddr`.
- `setPCReg` out 1: PC loads `setPC`.
- `setPC` out 64: register branch target.
- `linkWrite` out 1: write PC+4 into X30 (BL).
- `flags` out 4: registered NZCV.
- `inSlot` out 1: the current decode instruction is a delay-slot instruction.

## Operation
Decode:
- B: `instr[31:26]`=000101.
- BL: `instr[31:26]`=100101.
- CBZ: `instr[31:24]`=10110100.
- B.cond: `instr[31:24]`=01010100, condition code in `instr[4:0]`.
- BR: `instr[31:21]`=11010110000.

Offset generation:
- B/BL: `destAddr` = sext(`instr[25:0]`) << 2.
- CBZ/B.cond: `destAddr` = sext(`instr[23:5]`) << 2.
- Any other instruction: `destAddr` = 0.

Taken conditions, all gated by `instrValid` and by not being in SLOT:
- B and BL: always taken.
- CBZ: taken when `rtVal`==0.
- B.cond: taken when the condition evaluates true (see below).
- BR: always taken.
- B, BL, CBZ and B.cond assert `branchCond`. BR asserts `setPCReg`, and `setPC`=`rnVal`. `setPC` is 0 when BR is not taken.
- BL additionally asserts `linkWrite`.

Conditions:
- EQ(0x00): Z. NE(0x01): !Z.
- GE(0x0A): N==V. LT(0x0B): N!=V.
- GT(0x0C): !Z & N==V. LE(0x0D): !(!Z & N==V).
- Any other code: not taken.

Flag source:
- If `setFlags`=1 in the same cycle, B.cond evaluates against `aluFlags` (bypass).
- Otherwise it evaluates against the registered `flags`.

Delay-slot FSM:
- States are IDLE and SLOT.
- IDLE→SLOT on any taken branch with `instrValid`=1.
- SLOT→IDLE on the next cycle with `instrValid`=1. That instruction is the slot instruction and is always executed.
- SLOT holds while `instrValid`=0.
- In SLOT, a branch-type instruction is suppressed: `branchCond`, `setPCReg` and `linkWrite` are 0, and no state transition is triggered. `destAddr` is still computed.

Flags register:
- Loads `aluFlags` on the rising edge when `setFlags`=1.
- Independent of `instrValid` and of the FSM state.

## Timing
- `destAddr`, `branchCond`, `setPCReg`, `setPC`, `linkWrite` and `inSlot` are combinational from `instr`, the valid/forwarded inputs and current state: zero-cycle latency, so the PC captures the redirect at the next edge.
- FSM state and `flags` update at the rising edge.
- `inSlot` is high exactly while the state is SLOT.
- Reset, asynchronous at any time including mid-SLOT:
  - State returns to IDLE and `flags` clear to 0000.
  - All outputs read 0 while `reset`=1 (combinational outputs gated by `reset`).
  - The first valid instruction after reset release is evaluated normally.
- Simultaneous `setFlags` and flag-setting for the next instruction: the bypass covers the current B.cond, and the register captures the value for later ones.

## Configuration
- `BRANCH_PERF_EN` defined:
  - Adds output ports `branchCount` (32) and `takenCount` (32).
  - `branchCount` increments on every valid, non-suppressed branch-type instruction.
  - `takenCount` increments on every taken branch.
  - Both counters reset to 0, saturate at 0xFFFFFFFF, and are not incremented by suppressed slot branches.
- `BRANCH_PERF_EN` undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package `branch_pkg`:
  - Opcode constants (B, BL, CBZ, BCOND, BR).
  - Condition-code constants.
  - NZCV bit-index constants.
  - FSM state enum `{IDLE, SLOT}`.
- Sub-module `branch_cond_eval`: combinational, takes a 5-bit cond and 4-bit NZCV, returns `taken`.
- Flags and state registers reset to 0 / IDLE.

## Test plan
- B forward: `instr`=0x14000003, valid → `destAddr`=12, `branchCond`=1, `linkWrite`=0, and `inSlot`=1 next cycle.
- B backward / BL: `instr`=0x17FFFFF9 → `destAddr`=0xFFFFFFFFFFFFFFE4. `instr`=0x94000002 → `destAddr`=8, `branchCond`=1, `linkWrite`=1.
- CBZ X1 +2: `instr`=0xB4000041. With `rtVal`=0 → `branchCond`=1, `destAddr`=8. With `rtVal`=5 → `branchCond`=0, state stays IDLE.
- B.LT +4: `instr`=0x5400008B.
  - Registered `flags`=1000 → taken.
  - `flags`=1001 with `setFlags`=1 and `aluFlags`=1000 → taken via the bypass.
  - Next cycle `flags`=1000.
- BR X30 and slot suppression: `instr`=0xD61F03C0, `rnVal`=0x400 → `setPCReg`=1, `setPC`=0x400. Then a stall cycle keeps SLOT; then B 0x14000003 → `branchCond`=0, state returns to IDLE.
- Reset mid-SLOT: assert `reset` asynchronously while `inSlot`=1 → `inSlot`=0 and `flags`=0 immediately. After release, B 0x14000003 → `branchCond`=1.
